ddr5_req_scheduler: RTL and testbench

DDR5_REQ_SCHEDULER -- requirements
Module: ddr5_req_scheduler

---
 rtl/ddr5_req_scheduler.sv | 171 +++++++++++++++++
 tb/tb_ddr5_req_scheduler.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/ddr5_req_scheduler.sv
// DDR5 request scheduler: age-ordered request queue with open-row-first selection,
// same-address hazard ordering, starvation bound and a single output register.
module ddr5_req_scheduler #(
  parameter int DEPTH      = 8,
  parameter int ADDR_W     = 34,
  parameter int BANK_W     = 4,
  parameter int ROW_W      = 18,
  parameter int ID_W       = 8,
  parameter int DATA_W     = 128,
  parameter int MAX_BYPASS = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ADDR_W-1:0]        in_addr,
  input  logic [BANK_W-1:0]        in_bank,
  input  logic [ROW_W-1:0]         in_row,
  input  logic [ID_W-1:0]          in_id,
  input  logic                     in_is_write,
  input  logic [DATA_W-1:0]        in_wdata,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ADDR_W-1:0]        out_addr,
  output logic [BANK_W-1:0]        out_bank,
  output logic [ROW_W-1:0]         out_row,
  output logic [ID_W-1:0]          out_id,
  output logic                     out_is_write,
  output logic [DATA_W-1:0]        out_wdata,
  output logic                     out_row_hit,
  input  logic                     pre_all,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = IDX_W + 1;
  localparam int NBANK = 1 << BANK_W;
  localparam int BYP_W = $clog2(MAX_BYPASS + 1);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [BANK_W-1:0] bank;
    logic [ROW_W-1:0]  row;
    logic [ID_W-1:0]   id;
    logic              wr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  // Queue is kept compacted: slot 0 is always the oldest entry.
  req_t              q_q   [DEPTH];
  req_t              q_d   [DEPTH];
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  req_t              out_q, out_d;
  logic              out_valid_q, out_valid_d;
  logic              out_hit_q, out_hit_d;
  logic [NBANK-1:0]  tbl_v_q, tbl_v_d;
  logic [ROW_W-1:0]  tbl_row_q [NBANK];
  logic [ROW_W-1:0]  tbl_row_d [NBANK];
  logic [BYP_W-1:0]  byp_q, byp_d;
  logic              rdy_q;

  logic [NBANK-1:0]  tbl_v_eff;
  logic [DEPTH-1:0]  hit, elig;
  logic [IDX_W-1:0]  sel_idx;
  logic              found, load, push;
  logic [CNT_W-1:0]  cnt_after;
  req_t              in_req, sel_req;

  assign in_ready  = rdy_q && (cnt_q != CNT_W'(DEPTH));
  assign push      = in_valid && in_ready;
  assign load      = (cnt_q != '0) && (!out_valid_q || out_ready);
  assign cnt_after = cnt_q - CNT_W'(load);
  assign in_req    = '{addr: in_addr, bank: in_bank, row: in_row, id: in_id,
                       wr: in_is_write, wdata: in_wdata};
  assign sel_req   = q_q[sel_idx];

  always_comb begin
    tbl_v_eff = pre_all ? '0 : tbl_v_q;
    hit       = '0;
    elig      = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (CNT_W'(i) < cnt_q) begin
        hit[i]  = tbl_v_eff[q_q[i].bank] && (tbl_row_q[q_q[i].bank] == q_q[i].row);
        elig[i] = 1'b1;
        for (int unsigned j = 0; j < i; j++) begin
          if (q_q[j].addr == q_q[i].addr && (q_q[j].wr || q_q[i].wr))
            elig[i] = 1'b0;
        end
      end
    end
    sel_idx = '0;
    found   = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!found && elig[i] && hit[i]) begin
        sel_idx = IDX_W'(i);
        found   = 1'b1;
      end
    end
    if (byp_q >= BYP_W'(MAX_BYPASS))
      sel_idx = '0;
  end

  always_comb begin
    q_d = q_q;
    if (load) begin
      for (int unsigned i = 0; i < DEPTH - 1; i++) begin
        if (IDX_W'(i) >= sel_idx)
          q_d[i] = q_q[i + 1];
      end
    end
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (push && CNT_W'(i) == cnt_after)
        q_d[i] = in_req;
    end
    cnt_d = cnt_after + CNT_W'(push);

    byp_d = byp_q;
    if (load)
      byp_d = (sel_idx == '0) ? '0 : byp_q + 1'b1;
    if (cnt_d == '0)
      byp_d = '0;

    tbl_v_d   = tbl_v_eff;
    tbl_row_d = tbl_row_q;
    out_d       = out_q;
    out_hit_d   = out_hit_q;
    out_valid_d = out_valid_q && !out_ready;
    if (load) begin
      tbl_v_d[sel_req.bank]   = 1'b1;
      tbl_row_d[sel_req.bank] = sel_req.row;
      out_d       = sel_req;
      out_hit_d   = hit[sel_idx];
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) q_q[i] <= '0;
      for (int unsigned b = 0; b < NBANK; b++) tbl_row_q[b] <= '0;
      cnt_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      out_hit_q   <= 1'b0;
      tbl_v_q     <= '0;
      byp_q       <= '0;
      rdy_q       <= 1'b0;
    end else begin
      q_q         <= q_d;
      tbl_row_q   <= tbl_row_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      out_hit_q   <= out_hit_d;
      tbl_v_q     <= tbl_v_d;
      byp_q       <= byp_d;
      rdy_q       <= 1'b1;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_addr     = out_q.addr;
  assign out_bank     = out_q.bank;
  assign out_row      = out_q.row;
  assign out_id       = out_q.id;
  assign out_is_write = out_q.wr;
  assign out_wdata    = out_q.wdata;
  assign out_row_hit  = out_hit_q;
  assign occupancy    = cnt_q;

endmodule

// File: tb/tb_ddr5_req_scheduler.sv
// Directed bench for ddr5_req_scheduler: row-hit ordering, hazards, starvation,
// fill/backpressure, precharge-all and asynchronous reset.
module tb_ddr5_req_scheduler;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [33:0]  in_addr = '0;
  logic [3:0]   in_bank = '0;
  logic [17:0]  in_row = '0;
  logic [7:0]   in_id = '0;
  logic         in_is_write = 1'b0;
  logic [127:0] in_wdata = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [33:0]  out_addr;
  logic [3:0]   out_bank;
  logic [17:0]  out_row;
  logic [7:0]   out_id;
  logic         out_is_write;
  logic [127:0] out_wdata;
  logic         out_row_hit;
  logic         pre_all = 1'b0;
  logic [3:0]   occupancy;

  int n_vec  = 0;
  int n_miss = 0;
  logic [7:0] got_id  [16];
  logic       got_hit [16];
  logic       got_wr  [16];

  ddr5_req_scheduler #(.DEPTH(8), .MAX_BYPASS(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_bank(in_bank), .in_row(in_row), .in_id(in_id),
    .in_is_write(in_is_write), .in_wdata(in_wdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_bank(out_bank), .out_row(out_row), .out_id(out_id),
    .out_is_write(out_is_write), .out_wdata(out_wdata),
    .out_row_hit(out_row_hit), .pre_all(pre_all), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [33:0] a, input logic [3:0] b, input logic [17:0] r,
                       input logic [7:0] id, input logic w);
    in_valid = 1'b1; in_addr = a; in_bank = b; in_row = r; in_id = id;
    in_is_write = w; in_wdata = {16{id}};
  endtask

  task automatic push(input logic [33:0] a, input logic [3:0] b, input logic [17:0] r,
                      input logic [7:0] id, input logic w);
    chk("push_ready", in_ready, 1'b1);
    drive(a, b, r, id, w);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain(input int n);
    int k = 0;
    int budget = 0;
    out_ready = 1'b1;
    while (k < n && budget < 60) begin
      if (out_valid) begin
        got_id[k] = out_id; got_hit[k] = out_row_hit; got_wr[k] = out_is_write;
        k++;
      end
      tick();
      budget++;
    end
    out_ready = 1'b0;
    chk("drain_count", 128'(k), 128'(n));
  endtask

  initial begin
    #2;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_occ", occupancy, 4'd0);
    chk("rst_row_hit", out_row_hit, 1'b0);
    chk("rst_out_id", out_id, 8'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("ready_after_rst", in_ready, 1'b1);

    // First-access miss then same-row hit, with cycle-exact latency
    out_ready = 1'b1;
    push(34'h100, 4'd2, 18'd5, 8'h01, 1'b0);
    chk("a_occ", occupancy, 4'd1);
    chk("a_not_yet", out_valid, 1'b0);
    tick();
    chk("a_valid", out_valid, 1'b1);
    chk("a_id", out_id, 8'h01);
    chk("a_hit", out_row_hit, 1'b0);
    chk("a_occ0", occupancy, 4'd0);
    chk("a_wdata", out_wdata, {16{8'h01}});
    drive(34'h200, 4'd2, 18'd5, 8'h02, 1'b0);
    tick();
    in_valid = 1'b0;
    chk("b_gap", out_valid, 1'b0);
    chk("b_occ", occupancy, 4'd1);
    tick();
    chk("b_valid", out_valid, 1'b1);
    chk("b_id", out_id, 8'h02);
    chk("b_hit", out_row_hit, 1'b1);
    tick();
    chk("b_drop", out_valid, 1'b0);
    out_ready = 1'b0;

    // Row hit Z overtakes older miss Y
    out_ready = 1'b1;
    push(34'h1000, 4'd1, 18'd1, 8'h10, 1'b0);
    drain(1);
    push(34'h1100, 4'd4, 18'd2, 8'h11, 1'b0);
    push(34'h1200, 4'd1, 18'd9, 8'h12, 1'b0);
    push(34'h1300, 4'd1, 18'd1, 8'h13, 1'b0);
    chk("xyz_occ", occupancy, 4'd2);
    drain(3);
    chk("xyz_0", got_id[0], 8'h11);
    chk("xyz_1", got_id[1], 8'h13);
    chk("xyz_2", got_id[2], 8'h12);
    chk("z_hit", got_hit[1], 1'b1);
    chk("y_hit", got_hit[2], 1'b0);

    // Starvation bound: oldest miss forced after four bypasses
    push(34'h3000, 4'd3, 18'd7, 8'h30, 1'b0);
    push(34'h3100, 4'd5, 18'd1, 8'h31, 1'b0);
    for (int i = 0; i < 6; i++)
      push(34'h4000 + 34'(i * 16), 4'd3, 18'd7, 8'h40 + 8'(i), 1'b0);
    drain(8);
    chk("byp_0", got_id[0], 8'h30);
    chk("byp_1", got_id[1], 8'h40);
    chk("byp_2", got_id[2], 8'h41);
    chk("byp_3", got_id[3], 8'h42);
    chk("byp_4", got_id[4], 8'h43);
    chk("byp_5", got_id[5], 8'h31);
    chk("byp_6", got_id[6], 8'h44);
    chk("byp_7", got_id[7], 8'h45);
    chk("byp_hit1", got_hit[1], 1'b1);

    // Older write to same address blocks a younger row-hit read
    push(34'h600, 4'd6, 18'd3, 8'h50, 1'b0);
    push(34'h700, 4'd7, 18'd8, 8'h51, 1'b1);
    push(34'h700, 4'd6, 18'd3, 8'h52, 1'b0);
    drain(3);
    chk("haz_0", got_id[0], 8'h50);
    chk("haz_1", got_id[1], 8'h51);
    chk("haz_2", got_id[2], 8'h52);
    chk("haz_wr", got_wr[1], 1'b1);
    chk("haz_rd_hit", got_hit[2], 1'b1);

    // Precharge-all closes rows; the next load reopens
    pre_all = 1'b1;
    tick();
    pre_all = 1'b0;
    out_ready = 1'b1;
    push(34'h800, 4'd6, 18'd3, 8'h60, 1'b0);
    drain(1);
    chk("prea_miss", got_hit[0], 1'b0);
    push(34'h900, 4'd6, 18'd3, 8'h61, 1'b0);
    drain(1);
    chk("prea_reopen", got_hit[0], 1'b1);

    // Fill to full, stall stability, one pop, push+pop together
    for (int i = 0; i < 9; i++)
      push(34'hA000 + 34'(i * 16), 4'd8, 18'(i), 8'h70 + 8'(i), 1'b0);
    chk("full_occ", occupancy, 4'd8);
    chk("full_ready", in_ready, 1'b0);
    chk("full_valid", out_valid, 1'b1);
    chk("full_id", out_id, 8'h70);
    tick();
    chk("stall_id", out_id, 8'h70);
    chk("stall_occ", occupancy, 4'd8);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("pop_occ", occupancy, 4'd7);
    chk("pop_ready", in_ready, 1'b1);
    chk("pop_id", out_id, 8'h71);
    out_ready = 1'b1;
    drive(34'hB000, 4'd9, 18'd0, 8'h7F, 1'b0);
    tick();
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("pushpop_occ", occupancy, 4'd7);
    chk("pushpop_id", out_id, 8'h72);

    // Asynchronous reset mid-traffic
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", out_valid, 1'b0);
    chk("mrst_occ", occupancy, 4'd0);
    chk("mrst_ready", in_ready, 1'b0);
    chk("mrst_hit", out_row_hit, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("mrst_ready_up", in_ready, 1'b1);
    chk("mrst_still_empty", out_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
